weighted_vote_sequencer: RTL and testbench
==========================================

WEIGHTED_VOTE_SEQUENCER -- requirements
Module: weighted_vote_sequencer

Interface
- REQ-001: Parameter WBITS, default 4, SHALL set weight width; all arithmetic below assumes WBITS=4.
- REQ-002: Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
- REQ-003: Port rst, input, 1, SHALL be the reset: one clock; reset is asynchronous and active-high.
- REQ-004: Port start, input, 1, SHALL request one vote window; honoured only in IDLE.
- REQ-005: Port abort, input, 1, SHALL cancel the current window synchronously.
- REQ-006: Port cont, input, 1, SHALL select continuous mode, sampled in DECIDE.
- REQ-007: Port win_len, input, 4, SHALL give samples per window, latched on start accept; 0 means 16.
- REQ-008: Port bit_in, input, 1, SHALL be the serial vote bit, sampled each RUN cycle.
- REQ-009: Ports cfg_we (1), cfg_addr (2), cfg_data (WBITS), input, SHALL write weight register w[cfg_addr].
- REQ-010: Port vote, output, 1, SHALL hold the last decided majority value.
- REQ-011: Port vote_valid, output, 1, SHALL pulse one cycle per completed window.
- REQ-012: Port tie, output, 1, SHALL flag that the last window ended in a tie.
- REQ-013: Port busy, output, 1, SHALL be high in RUN and DECIDE.

Function
- REQ-014: FSM states SHALL be IDLE, RUN, DECIDE; IDLE->RUN on start; RUN->DECIDE after the last sample; DECIDE->RUN if cont=1, else IDLE.
- REQ-015: Start accepted at edge E0 SHALL sample bit_in at edges E1..EN (N = effective win_len); DECIDE registers outputs at edge E(N+1); vote_valid high only during the cycle after E(N+1).
- REQ-016: Sample k (0-based) SHALL use weight w[k mod 4], added to sum1 if bit_in=1, else to sum0.
- REQ-017: sum0 and sum1 SHALL be 8 bits unsigned; max 16*15=240, no overflow, no saturation needed.
- REQ-018: Decision: sum1>sum0 -> vote=1, tie=0; sum0>sum1 -> vote=0, tie=0; equal -> vote unchanged, tie=1.
- REQ-019: Sums and sample counter SHALL clear on start accept and on DECIDE exit.
- REQ-020: In cont mode, the next window SHALL reuse the latched win_len; first new sample at E(N+2); bit_in ignored in DECIDE.
- REQ-021: cfg_we SHALL take effect only in IDLE; writes while busy are dropped.
- REQ-022: start while busy SHALL be ignored.
- REQ-023: abort in RUN or DECIDE SHALL force IDLE next edge, clear sums/counter, suppress vote_valid, leave vote/tie unchanged; abort has priority over start and cont.
- REQ-024: abort in IDLE SHALL have no effect.

Reset
- REQ-025: rst SHALL asynchronously force IDLE, sums/counter=0, vote=0, tie=0, vote_valid=0, busy=0.
- REQ-026: rst SHALL set all weights w[0..3]=1 (plain majority).
- REQ-027: rst mid-window SHALL discard the window; no vote_valid after release until a new start completes.

Verification
- REQ-028: Default weights, win_len=15, bits 0x4,1x5,0x6 -> sum0=10, sum1=5, vote=0, tie=0, vote_valid one cycle, 16 edges after start.
- REQ-029: w=[8,1,1,1], win_len=4, bits 1,0,0,0 -> sum1=8, sum0=3, vote=1.
- REQ-030: Prior vote=1, default weights, win_len=2, bits 1,0 -> tie=1, vote stays 1.
- REQ-031: cont=1, win_len=3, bits 1,1,0,<gap>,0,0,1 -> two vote_valid pulses 4 cycles apart, vote 1 then 0; busy stays high throughout.
- REQ-032: abort at sample 2 of win_len=8 -> IDLE, no vote_valid, vote unchanged; cfg_we during RUN leaves weights unchanged.
- REQ-033: rst asserted mid-RUN -> immediate busy=0, vote=0, weights=1; subsequent start with win_len=0 completes after 16 samples.

Source files
------------

// File: rtl/weighted_vote_sequencer.sv
// weighted_vote_sequencer: weighted serial majority vote over windows of win_len samples (clk, rst, start/abort/cont, win_len, bit_in, cfg_* in; vote, vote_valid, tie, busy out)
module weighted_vote_sequencer #(
  parameter int WBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [3:0]       win_len,
  input  logic             bit_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WBITS-1:0] cfg_data,
  output logic             vote,
  output logic             vote_valid,
  output logic             tie,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DECIDE = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt, len;
  logic [7:0] sum0, sum1, wk;
  logic [WBITS-1:0] w [4];
  assign busy = state != IDLE;
  assign wk = 8'(w[cnt[1:0]]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      sum0 <= '0;
      sum1 <= '0;
      vote <= 1'b0;
      tie <= 1'b0;
      vote_valid <= 1'b0;
      for (int i = 0; i < 4; i++) w[i] <= WBITS'(1);
    end else begin
      vote_valid <= 1'b0;
      if (state == IDLE) begin
        if (cfg_we) w[cfg_addr] <= cfg_data;
        if (start) begin
          state <= RUN;
          len <= win_len == 4'd0 ? 5'd16 : {1'b0, win_len};
          cnt <= '0;
          sum0 <= '0;
          sum1 <= '0;
        end
      end else if (abort) begin
        state <= IDLE;
        cnt <= '0;
        sum0 <= '0;
        sum1 <= '0;
      end else if (state == RUN) begin
        if (bit_in) sum1 <= sum1 + wk;
        else sum0 <= sum0 + wk;
        cnt <= cnt + 5'd1;
        if (cnt == len - 5'd1) state <= DECIDE;
      end else if (state == DECIDE) begin
        vote_valid <= 1'b1;
        tie <= sum1 == sum0;
        vote <= sum1 > sum0 || (sum1 == sum0 && vote);
        cnt <= '0;
        sum0 <= '0;
        sum1 <= '0;
        state <= cont ? RUN : IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_weighted_vote_sequencer.sv
// tb_weighted_vote_sequencer: randomized and directed checks of weighted_vote_sequencer against a window-level model
module tb_weighted_vote_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cont = 1'b0, bit_in = 1'b0, cfg_we = 1'b0;
  logic [3:0] win_len = '0, cfg_data = '0;
  logic [1:0] cfg_addr = '0;
  logic vote, vote_valid, tie, busy;
  int checks = 0, errors = 0;
  int mw [4];
  logic mvote = 1'b0, mtie = 1'b0;
  weighted_vote_sequencer #(.WBITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .win_len(win_len),
    .bit_in(bit_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .vote(vote), .vote_valid(vote_valid), .tie(tie), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(vote_valid), 0);
      check("idle_vote", 32'(vote), 32'(mvote));
    end
  endtask
  task automatic cfg(input logic [1:0] a, input logic [3:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    mw[a] = int'(d);
    check("cfg_busy", 32'(busy), 0);
  endtask
  task automatic start_win(input logic [3:0] wl);
    start = 1'b1;
    win_len = wl;
    cfg_we = 1'b0;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_valid", 32'(vote_valid), 0);
  endtask
  // busy-time noise: start, win_len and cfg writes must all be ignored
  task automatic feed(input int n, input logic [15:0] bits);
    for (int k = 0; k < n; k++) begin
      bit_in = bits[k];
      start = 1'($urandom);
      win_len = 4'($urandom);
      cfg_we = 1'($urandom);
      cfg_addr = 2'($urandom);
      cfg_data = 4'($urandom);
      tick();
      check("run_busy", 32'(busy), 1);
      check("run_valid", 32'(vote_valid), 0);
    end
  endtask
  task automatic win(input int n, input logic [15:0] bits, input logic cv);
    int s0 = 0, s1 = 0;
    feed(n, bits);
    for (int k = 0; k < n; k++)
      if (bits[k]) s1 += mw[k % 4];
      else s0 += mw[k % 4];
    mtie = s0 == s1;
    mvote = s1 > s0 ? 1'b1 : s0 > s1 ? 1'b0 : mvote;
    start = 1'b0;
    cfg_we = 1'b0;
    cont = cv;
    bit_in = 1'($urandom);
    tick();
    cont = 1'b0;
    check("dec_valid", 32'(vote_valid), 1);
    check("dec_vote", 32'(vote), 32'(mvote));
    check("dec_tie", 32'(tie), 32'(mtie));
    check("dec_busy", 32'(busy), 32'(cv));
  endtask
  initial begin
    logic cv;
    logic [3:0] wl;
    for (int i = 0; i < 4; i++) mw[i] = 1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_vote", 32'(vote), 0);
    check("rst_tie", 32'(tie), 0);
    check("rst_valid", 32'(vote_valid), 0);
    tick();
    rst = 1'b0;
    idle(2);
    start_win(4'd15);
    win(15, 16'h01F0, 1'b0);
    idle(2);
    cfg(2'd0, 4'd8);
    start_win(4'd4);
    win(4, 16'h0001, 1'b0);
    check("w8_vote", 32'(vote), 1);
    cfg(2'd0, 4'd1);
    start_win(4'd2);
    win(2, 16'h0001, 1'b0);
    check("tie_flag", 32'(tie), 1);
    check("tie_vote", 32'(vote), 1);
    idle(1);
    start_win(4'd3);
    win(3, 16'h0003, 1'b1);
    win(3, 16'h0004, 1'b0);
    check("cont_vote", 32'(vote), 0);
    idle(1);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    start_win(4'd8);
    feed(2, 16'h0003);
    abort = 1'b1;
    start = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 4'd15;
    tick();
    abort = 1'b0;
    start = 1'b0;
    cfg_we = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(vote_valid), 0);
    check("abort_vote", 32'(vote), 32'(mvote));
    idle(3);
    start_win(4'd2);
    win(2, 16'h0001, 1'b0);
    check("abort_w_tie", 32'(tie), 1);
    start_win(4'd1);
    win(1, 16'h0001, 1'b0);
    cfg(2'd2, 4'd9);
    start_win(4'd5);
    feed(2, 16'h0000);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) mw[i] = 1;
    mvote = 1'b0;
    mtie = 1'b0;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_vote", 32'(vote), 0);
    check("mrst_tie", 32'(tie), 0);
    check("mrst_valid", 32'(vote_valid), 0);
    start = 1'b0;
    cfg_we = 1'b0;
    tick();
    rst = 1'b0;
    idle(3);
    start_win(4'd0);
    win(16, 16'h5A5A, 1'b0);
    start_win(4'd3);
    win(3, 16'h0004, 1'b0);
    check("w2_reset_vote", 32'(vote), 0);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(2) == 0) cfg(2'($urandom), 4'($urandom));
      wl = 4'($urandom);
      start_win(wl);
      for (int c = 0; c < 3; c++) begin
        cv = c < 2 && $urandom_range(2) == 0;
        win(wl == 4'd0 ? 16 : int'(wl), 16'($urandom), cv);
        if (!cv) break;
      end
      idle(1 + $urandom_range(1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
